// File: rtl/misao_memory_if.sv
// Core bus and host loader stream between the misao core/host and misao_memory.
interface misao_memory_if;
  logic        mem_enable_read;
  logic        mem_enable_write;
  logic [14:0] mem_addr;
  logic        mem_rw;
  logic [7:0]  mem_data_out;
  logic [7:0]  mem_data_in;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;

  modport master (
    output mem_enable_read, mem_enable_write, mem_addr, mem_rw, mem_data_out,
    input  mem_data_in,
    output ld_valid, ld_data,
    input  ld_ready
  );

  modport slave (
    input  mem_enable_read, mem_enable_write, mem_addr, mem_rw, mem_data_out,
    output mem_data_in,
    input  ld_valid, ld_data,
    output ld_ready
  );
endinterface

// File: rtl/misao_memory.sv
// Byte-wide memory responder for the misao core: host-stream loader, MMIO debug
// register with write counter, and a sticky out-of-range fault flag.
module misao_memory #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [14:0] MMIO_ADDR = 15'h7FFF
) (
  input  logic                 clk,
  input  logic                 rst,
  misao_memory_if.slave        bus,
  output logic                 core_rst,
  output logic                 dbg_valid,
  output logic [7:0]           dbg_data,
  output logic                 fault
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {LEN_LO, LEN_HI, DATA, RUN} state_t;

  state_t      state, state_nxt;
  logic [15:0] len;
  logic [15:0] cnt;
  logic [7:0]  mmio_cnt;
  logic [7:0]  mem [DEPTH];

  logic accept;
  logic run;
  logic in_range;
  logic mmio_hit;
  logic load_in_range;
  logic unused_rw;

  // Direction hint is redundant with the strobes.
  assign unused_rw = bus.mem_rw;

  assign run           = (state == RUN);
  assign in_range      = 32'(bus.mem_addr) < DEPTH;
  assign mmio_hit      = (bus.mem_addr == MMIO_ADDR);
  assign load_in_range = 32'(cnt) < DEPTH;
  assign bus.ld_ready  = rst && (state != RUN);
  assign accept        = bus.ld_valid && bus.ld_ready;

  always_ff @(posedge clk) begin
    if (!rst) state <= LEN_LO;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    core_rst  = (state != RUN);
    case (state)
      LEN_LO: if (accept) state_nxt = LEN_HI;
      LEN_HI: if (accept) state_nxt = ({bus.ld_data, len[7:0]} == '0) ? RUN : DATA;
      DATA:   if (accept && (cnt == len - 16'd1)) state_nxt = RUN;
      default: state_nxt = state;
    endcase
  end

  always_comb begin
    bus.mem_data_in = '0;
    if (run) begin
      if (in_range)      bus.mem_data_in = mem[bus.mem_addr[AW-1:0]];
      else if (mmio_hit) bus.mem_data_in = mmio_cnt;
    end
  end

  // Array has no reset: contents survive both reset and reload aborts.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == DATA && accept && load_in_range)
        mem[cnt[AW-1:0]] <= bus.ld_data;
      else if (run && bus.mem_enable_write && in_range)
        mem[bus.mem_addr[AW-1:0]] <= bus.mem_data_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      len       <= '0;
      cnt       <= '0;
      mmio_cnt  <= '0;
      dbg_valid <= 1'b0;
      dbg_data  <= '0;
      fault     <= 1'b0;
    end else begin
      dbg_valid <= 1'b0;
      if (accept) begin
        case (state)
          LEN_LO: len[7:0]  <= bus.ld_data;
          LEN_HI: len[15:8] <= bus.ld_data;
          DATA: begin
            cnt <= cnt + 16'd1;
            if (!load_in_range) fault <= 1'b1;
          end
          default: ;
        endcase
      end
      if (run) begin
        if (bus.mem_enable_write && mmio_hit) begin
          dbg_data  <= bus.mem_data_out;
          dbg_valid <= 1'b1;
          mmio_cnt  <= mmio_cnt + 8'd1;
        end
        if (!in_range && !mmio_hit && (bus.mem_enable_read || bus.mem_enable_write))
          fault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_misao_memory.sv
// Randomized scoreboard bench for misao_memory against a byte-count loader model.
module tb_misao_memory;

  logic       clk = 1'b0;
  logic       rst;
  logic       core_rst;
  logic       dbg_valid;
  logic [7:0] dbg_data;
  logic       fault;

  always #5 clk = ~clk;

  misao_memory_if bus ();

  misao_memory #(.DEPTH(256), .MMIO_ADDR(15'h7FFF)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .core_rst (core_rst),
    .dbg_valid(dbg_valid),
    .dbg_data (dbg_data),
    .fault    (fault)
  );

  typedef struct {
    int         sig;
    logic [7:0] val;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] dbg_q[$];
  int         total  = 0;
  int         passed = 0;

  // Reference model: loader progress is just "bytes accepted since reset".
  bit         mvalid = 1'b0;
  int         acc;
  int         n;
  logic [7:0] marr[256];
  bit         known[256];
  int         ctr;
  bit         mfault;
  bit         mdbgv;
  logic [7:0] mdbgd;

  function automatic bit m_run();
    return mvalid && acc >= 2 && (acc - 2) >= n;
  endfunction

  function automatic void check(string name, logic [7:0] act, logic [7:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: actual %02h required %02h", name, act, expv);
  endfunction

  function automatic void push(int s, logic [7:0] v);
    exp_t e;
    e.sig = s;
    e.val = v;
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      case (e.sig)
        0: check("mem_data_in", bus.mem_data_in, e.val);
        1: check("ld_ready", 8'(bus.ld_ready), e.val);
        2: check("core_rst", 8'(core_rst), e.val);
        3: check("fault", 8'(fault), e.val);
        4: check("dbg_valid", 8'(dbg_valid), e.val);
        default: check("dbg_data", dbg_data, e.val);
      endcase
    end
    if (dbg_valid === 1'b1) begin
      if (dbg_q.size() == 0) check("dbg_pulse_unexpected", 8'(dbg_valid), 8'd0);
      else check("dbg_pulse_data", dbg_data, dbg_q.pop_front());
    end
  end

  task automatic step(input bit r, input bit lv, input logic [7:0] ld,
                      input bit re, input bit we, input logic [14:0] a,
                      input logic [7:0] wd);
    bit run_now;
    int k;
    int ai;
    rst                  = r;
    bus.ld_valid         = lv;
    bus.ld_data          = ld;
    bus.mem_enable_read  = re;
    bus.mem_enable_write = we;
    bus.mem_addr         = a;
    bus.mem_data_out     = wd;
    bus.mem_rw           = 1'($urandom);
    run_now = m_run();
    ai = int'(a);
    if (mvalid) begin
      push(1, 8'(r && !run_now));
      push(2, 8'(!run_now));
      push(3, 8'(mfault));
      push(4, 8'(mdbgv));
      push(5, mdbgd);
      if (!run_now) push(0, 8'h00);
      else if (ai < 256) begin
        if (known[ai]) push(0, marr[ai]);
      end else if (ai == 32'h7FFF) push(0, 8'(ctr));
      else push(0, 8'h00);
    end
    @(posedge clk);
    if (!r) begin
      acc = 0; n = 0; ctr = 0; mfault = 0; mdbgv = 0; mdbgd = 8'h00;
      mvalid = 1'b1;
    end else if (mvalid) begin
      mdbgv = 1'b0;
      if (!run_now) begin
        if (lv) begin
          if (acc == 0) n = int'(ld);
          else if (acc == 1) n = n + int'(ld) * 256;
          else begin
            k = acc - 2;
            if (k < 256) begin marr[k] = ld; known[k] = 1'b1; end
            else mfault = 1'b1;
          end
          acc++;
        end
      end else begin
        if (we) begin
          if (ai < 256) begin marr[ai] = wd; known[ai] = 1'b1; end
          else if (ai == 32'h7FFF) begin
            mdbgd = wd; mdbgv = 1'b1; ctr = (ctr + 1) % 256; dbg_q.push_back(wd);
          end else mfault = 1'b1;
        end
        if (re && ai >= 256 && ai != 32'h7FFF) mfault = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle();
    step(1, 0, 8'($urandom), 0, 0, 15'($urandom_range(0, 255)), 8'($urandom));
  endtask

  // Loader byte with random core strobes, which must be ignored outside RUN.
  task automatic ld(input logic [7:0] b);
    step(1, 1, b, 1'($urandom), 1'($urandom), 15'($urandom), 8'($urandom));
  endtask

  task automatic rd(input logic [14:0] a);
    step(1, 0, 8'($urandom), 1, 0, a, 8'($urandom));
  endtask

  task automatic wr(input logic [14:0] a, input logic [7:0] d);
    step(1, 0, 8'($urandom), 0, 1, a, d);
  endtask

  task automatic reset_n(input int cycles);
    for (int i = 0; i < cycles; i++)
      step(0, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
           15'($urandom), 8'($urandom));
  endtask

  initial begin
    rst = 1'b0;
    bus.ld_valid = 0; bus.ld_data = '0; bus.mem_enable_read = 0;
    bus.mem_enable_write = 0; bus.mem_addr = '0; bus.mem_data_out = '0; bus.mem_rw = 0;
    @(posedge clk); #1;

    reset_n(3);
    rd(15'h0001); rd(15'h7FFF);

    ld(8'h03); ld(8'h00); ld(8'h1A); ld(8'h2B); idle(); ld(8'h3C);
    rd(15'h0001); rd(15'h0000); rd(15'h0002);

    wr(15'h0010, 8'h5A); rd(15'h0010);
    step(1, 0, 8'h00, 1, 1, 15'h0010, 8'hA5); rd(15'h0010);

    wr(15'h7FFF, 8'h41); idle(); rd(15'h7FFF);
    for (int i = 0; i < 256; i++) wr(15'h7FFF, 8'($urandom));
    rd(15'h7FFF);
    wr(15'h7FFF, 8'h11); wr(15'h7FFF, 8'h22); idle(); idle();

    rd(15'h0100); idle(); idle();

    for (int i = 0; i < 200; i++) begin
      int sel;
      logic [14:0] a;
      sel = int'($urandom_range(0, 9));
      if (sel < 6)      a = 15'($urandom_range(0, 255));
      else if (sel < 8) a = 15'h7FFF;
      else              a = 15'($urandom_range(256, 32766));
      step(1, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), a, 8'($urandom));
    end

    reset_n(2);
    ld(8'h00); ld(8'h00);
    for (int i = 0; i < 3; i++) step(1, 1, 8'($urandom), 0, 0, 15'h0001, 8'h00);
    rd(15'h0001); rd(15'h0010);

    reset_n(1);
    ld(8'h02); ld(8'h01);
    for (int i = 0; i < 258; i++) begin
      while ($urandom_range(0, 3) == 0) idle();
      ld(8'($urandom));
    end
    for (int i = 0; i < 256; i++) rd(15'(i));

    reset_n(1);
    ld(8'h0A); ld(8'h00);
    for (int i = 0; i < 4; i++) ld(8'($urandom));
    reset_n(1);
    idle(); idle();
    ld(8'h01); ld(8'h00); ld(8'h77);
    rd(15'h0000); rd(15'h0005);
    idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/misao_memory.md
# misao_memory

Byte-wide memory responder for the `misao` core bus: serves instruction/data fetches and stores on the core's 15-bit address / 8-bit data interface. A loader FSM fills the array from a host byte stream while holding the core in reset. The block also provides one MMIO debug-output register and a sticky out-of-range fault flag. It sits between the `misao` core and the SoC/bench host and replaces the behavioural memory model in system-level benches.

## Interface
- `DEPTH`, 256: array size in bytes; power of two, ≤ 32768.
- `MMIO_ADDR`, 15'h7FFF: debug-output register address; must be ≥ `DEPTH`.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `mem_enable_read`  in  1  core read strobe.
- `mem_enable_write`  in  1  core write strobe.
- `mem_addr`  in  15  core byte address.
- `mem_rw`  in  1  core direction hint; ignored, strobes are authoritative.
- `mem_data_out`  in  8  core write data.
- `mem_data_in`  out  8  read data to core; combinational.
- `ld_valid`  in  1  host byte valid.
- `ld_data`  in  8  host byte.
- `ld_ready`  out  1  block accepts a host byte this cycle.
- `core_rst`  out  1  active-high reset to the core; high until load completes.
- `dbg_valid`  out  1  one-cycle pulse on an MMIO write.
- `dbg_data`  out  8  last MMIO write value.
- `fault`  out  1  sticky out-of-range access flag.

## Operation
- FSM states: `LEN_LO` → `LEN_HI` → `DATA` → `RUN`. Advance only on accept, where accept = `ld_valid & ld_ready`.
- `LEN_LO` / `LEN_HI` latch the 16-bit byte count N, low byte first.
  - If N = 0, `LEN_HI` goes directly to `RUN`.
- `DATA`: the k-th accepted byte (k = 0..N-1) is written to `array[k]`.
  - Bytes with k ≥ `DEPTH` are consumed but discarded, and set `fault`.
  - The accept of byte N-1 moves the FSM to `RUN`.
- `ld_ready` = 1 in `LEN_LO`/`LEN_HI`/`DATA`, 0 in `RUN`, and forced 0 while `rst` is low.
- `core_rst` = (state ≠ `RUN`). The array is not cleared by reset; locations not loaded keep their prior contents (simulation initialises them to 00).
- Core accesses are honoured only in `RUN`. Outside `RUN`, strobes are ignored, no fault is raised, and `mem_data_in` = 00.
- Read (`RUN`):
  - `mem_addr < DEPTH` → `array[mem_addr]`.
  - `mem_addr == MMIO_ADDR` → 8-bit MMIO write counter.
  - Otherwise → 00. If `mem_enable_read` is high, `fault` sets.
- Write (`RUN`, `mem_enable_write`):
  - `mem_addr < DEPTH` → `array[mem_addr] <= mem_data_out`.
  - `mem_addr == MMIO_ADDR` → register `dbg_data <= mem_data_out`; `dbg_valid` = 1 for the next cycle only; counter += 1, wrapping 255 → 0.
  - Otherwise → write dropped, `fault` sets.
- Read and write strobes together: the write is performed at the edge. `mem_data_in` in that cycle shows pre-write contents.
- `fault` clears only on reset.

## Timing
- Reset values: state `LEN_LO`, N = 0, k = 0, `core_rst` = 1, `ld_ready` = 0 during reset and 1 after, `dbg_valid` = 0, `dbg_data` = 00, counter = 00, `fault` = 0, `mem_data_in` = 00.
- Read latency: 0 cycles, combinational from `mem_addr` and state. The core samples it in the same cycle.
- Write visibility: data written at edge t is readable from cycle t+1.
- `dbg_valid` rises the cycle after the MMIO write edge, for exactly 1 cycle. Back-to-back MMIO writes give consecutive pulses.
- Loader throughput: 1 byte/cycle; `ld_valid` gaps are allowed.
- `core_rst` falls in the cycle after the last accepted byte. Minimum from reset release to `RUN` is N+2 accepts.
- `rst` low mid-load or mid-run: the next edge returns all state to reset values. The partially received count is discarded; array contents are retained.

## Test plan
1. Hold `rst` low for 3 cycles, then release → `core_rst` = 1, `ld_ready` = 1, `dbg_valid` = 0, `fault` = 0, `mem_data_in` = 00 for any address.
2. Stream 03, 00, 1A, 2B, 3C with one idle cycle between 2B and 3C → `array[0..2]` = 1A/2B/3C; `core_rst` and `ld_ready` fall the cycle after 3C; read addr 1 → 2B.
3. Header 00, 00 → `RUN` entered on the second accept, no `DATA` cycles; extra `ld_valid` is not accepted.
4. `RUN`:
   - Write 5A to 0x010, then read 0x010 next cycle → 5A.
   - Simultaneous read/write A5 to 0x010 → `mem_data_in` = 5A that cycle, A5 the next.
5. Write 41 to 0x7FFF → `dbg_valid` high 1 cycle, `dbg_data` = 41; read 0x7FFF → 01. After 256 MMIO writes, read → 00.
6. Fault and reset cases:
   - `DEPTH` = 256, read 0x0100 → 00 and `fault` = 1, held until reset.
   - Load N = 0x0102 → last 2 bytes dropped and `fault` = 1.
   - Assert `rst` mid-`DATA` → `LEN_LO`, `core_rst` = 1.
